inv_subbytes_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 18 +
 rtl/inv_subbytes_seq_if.sv | 23 ++
 rtl/inv_sbox.sv | 34 +++
 rtl/inv_subbytes_seq.sv | 77 +++++++
 tb/tb_inv_subbytes_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvSubBytes engine: state geometry, FSM
// states and the InvShiftRows destination map.
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [7:0] state_t [0:AES_BYTES-1];

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // Row r of the state rotates right by r columns.
  function automatic int inv_shift_idx(int i);
    int r, c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c + r) % 4);
  endfunction
endpackage

// File: rtl/inv_subbytes_seq_if.sv
// Valid/ready bundle between the InvMixColumns stage, the InvSubBytes engine
// and the round register. The engine takes the slave side.
interface inv_subbytes_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_data;
  logic                   busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map, then the GF(2^8)
// multiplicative inverse computed as x^254 (0 maps to 0).
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_aff;

  // rotl1 ^ rotl3 ^ rotl6 ^ 0x05 undoes the forward affine transform
  assign w_aff = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                 {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

  always_comb begin
    logic [7:0] v_pow, v_acc;
    v_pow = w_aff;
    v_acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      v_pow = gf_mul(v_pow, v_pow);
      v_acc = gf_mul(v_acc, v_pow);
    end
    o_byte = v_acc;
  end
endmodule

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed InvSubBytes: LANES shared inv_sbox instances walk the 16
// state bytes over 16/LANES cycles. INV_SUBBYTES_SHIFT_EN folds InvShiftRows into the result write.
module inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  inv_subbytes_seq_if.slave bus
);
  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_e                  r_state, w_nxt;
  logic [CW-1:0]         r_grp;
  state_t                r_src, r_res;
  logic                  w_grp_last;
  logic [LANES-1:0][3:0] w_src_idx, w_dst_idx;
  logic [LANES-1:0][7:0] w_sb_in, w_sb_out;

  assign w_grp_last = (r_grp == CW'(N - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_src_idx[l] = 4'(int'(r_grp) * LANES + l);
`ifdef INV_SUBBYTES_SHIFT_EN
    assign w_dst_idx[l] = 4'(inv_shift_idx(int'(w_src_idx[l])));
`else
    assign w_dst_idx[l] = w_src_idx[l];
`endif
    assign w_sb_in[l] = r_src[w_src_idx[l]];
    inv_sbox u_sbox (.i_byte(w_sb_in[l]), .o_byte(w_sb_out[l]));
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_nxt = RUN;
      RUN:     if (w_grp_last)    w_nxt = DONE;
      DONE:    if (bus.out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grp   <= '0;
      r_src   <= '{default: '0};
      r_res   <= '{default: '0};
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && bus.in_valid) begin
        for (int i = 0; i < AES_BYTES; i++)
          r_src[i] <= bus.in_data[AES_STATE_W-1-8*i -: 8];
        r_grp <= '0;
      end
      if (r_state == RUN) begin
        r_grp <= w_grp_last ? '0 : r_grp + CW'(1);
        for (int l = 0; l < LANES; l++)
          r_res[w_dst_idx[l]] <= w_sb_out[l];
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN);

  for (genvar i = 0; i < AES_BYTES; i++) begin : g_out
    assign bus.out_data[AES_STATE_W-1-8*i -: 8] = r_res[i];
  end
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: five DUTs (LANES 4,1,2,8,16) checked every cycle
// against a transaction-level model built on a software inverse S-box table.
module tb_inv_subbytes_seq;
  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   inv_tab [256];
  logic         rst_a [NI];
  logic         iv_a  [NI];
  logic         or_a  [NI];
  logic [127:0] id_a  [NI];
  logic         ir_a  [NI];
  logic         ov_a  [NI];
  logic         bz_a  [NI];
  logic [127:0] od_a  [NI];

  // model state and negedge snapshots
  bit           pend [NI];
  bit           armed [NI];
  bit           just_rst [NI];
  int           age [NI];
  logic [127:0] exp_d [NI];
  bit           p_rst [NI];
  bit           p_acc [NI];
  bit           p_ohs [NI];
  logic [127:0] p_d [NI];
  logic         s_ir [NI];
  logic         s_ov [NI];
  logic [127:0] s_od [NI];

  function automatic int lanes_of(int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic void chk(string nm, int k, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d L=%0d: got %h expected %h", nm, k, lanes_of(k), act, exp);
    end
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] model(logic [127:0] d);
    logic [127:0] o;
    int dst;
    o = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef INV_SUBBYTES_SHIFT_EN
      dst = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
`else
      dst = i;
`endif
      o[127-8*dst -: 8] = inv_tab[d[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 16;
    inv_subbytes_seq_if u_if ();
    assign u_if.in_valid  = iv_a[k];
    assign u_if.in_data   = id_a[k];
    assign u_if.out_ready = or_a[k];
    assign ir_a[k] = u_if.in_ready;
    assign ov_a[k] = u_if.out_valid;
    assign bz_a[k] = u_if.busy;
    assign od_a[k] = u_if.out_data;
    inv_subbytes_seq #(.LANES(L)) u_dut (.clk(clk), .rst_n(rst_a[k]), .bus(u_if));
  end

  // Advance the model past the previous edge, compare, then record what the
  // coming edge will do.
  function automatic void step(int k);
    int n;
    bit ev;
    n = 16 / lanes_of(k);
    if (!p_rst[k]) begin
      pend[k] = 0; armed[k] = 1; just_rst[k] = 1;
    end else begin
      just_rst[k] = 0;
      if (p_ohs[k]) pend[k] = 0;
      else if (p_acc[k]) begin pend[k] = 1; age[k] = 0; exp_d[k] = model(p_d[k]); end
      else if (pend[k]) age[k]++;
    end
    ev = pend[k] && (age[k] >= n);
    s_ir[k] = ir_a[k];
    s_ov[k] = ov_a[k];
    s_od[k] = od_a[k];
    if (armed[k]) begin
      chk("in_ready", k, 128'(ir_a[k]), 128'(!pend[k]));
      chk("out_valid", k, 128'(ov_a[k]), 128'(ev));
      chk("busy", k, 128'(bz_a[k]), 128'(pend[k] && age[k] < n));
      if (ev) chk("out_data", k, od_a[k], exp_d[k]);
      if (just_rst[k]) chk("out_data_rst", k, od_a[k], 128'h0);
    end
    p_rst[k] = rst_a[k];
    p_acc[k] = rst_a[k] && !pend[k] && iv_a[k];
    p_ohs[k] = rst_a[k] && ev && or_a[k];
    p_d[k]   = id_a[k];
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [127:0] d);
    int t;
    t = 0;
    iv_a[k] = 1'b1;
    id_a[k] = d;
    do begin tick(); t++; end while (!s_ir[k] && t < 200);
    if (!s_ir[k]) chk("send_timeout", k, 128'(s_ir[k]), 128'h1);
    iv_a[k] = 1'b0;
    id_a[k] = rnd128();
  endtask

  task automatic collect(int k, int stall, output logic [127:0] res);
    int lat;
    or_a[k] = (stall == 0);
    lat = 0;
    tick();
    while (!s_ov[k] && lat < 40) begin lat++; tick(); end
    chk("latency", k, 128'(lat), 128'(16 / lanes_of(k)));
    res = s_od[k];
    if (stall > 0) begin
      repeat (stall) tick();
      or_a[k] = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [7:0]   gi, s;
    logic [127:0] res, d;
    int           n, cnt;

    for (int x = 0; x < 256; x++) begin
      gi = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) gi = 8'(y);
      s = gi ^ rotl(gi, 1) ^ rotl(gi, 2) ^ rotl(gi, 3) ^ rotl(gi, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
    chk("pin_63", 0, 128'(inv_tab[8'h63]), 128'h00);
    chk("pin_00", 0, 128'(inv_tab[8'h00]), 128'h52);
    chk("pin_7c", 0, 128'(inv_tab[8'h7c]), 128'h01);
    chk("pin_01", 0, 128'(inv_tab[8'h01]), 128'h09);
    chk("pin_ff", 0, 128'(inv_tab[8'hff]), 128'h7d);

    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b0; iv_a[k] = 1'b0; or_a[k] = 1'b1; id_a[k] = '0;
      pend[k] = 0; armed[k] = 0; just_rst[k] = 0; age[k] = 0; exp_d[k] = '0;
      p_rst[k] = 1; p_acc[k] = 0; p_ohs[k] = 0; p_d[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < NI; k++) rst_a[k] = 1'b1;
    tick();

    // directed patterns on the LANES=4 instance
    send(0, {16{8'h63}});
    collect(0, 0, res);
    chk("all63", 0, res, 128'h0);
    send(0, {16{8'h00}});
    collect(0, 0, res);
    chk("all00", 0, res, {16{8'h52}});
    send(0, 128'h000102030405060708090a0b0c0d0e0f);
    collect(0, 0, res);
`ifdef INV_SUBBYTES_SHIFT_EN
    chk("seq_b0", 0, 128'(res[127:120]), 128'h52);
    chk("seq_b5", 0, 128'(res[87:80]), 128'h09);
`else
    chk("seq", 0, res, 128'h52096ad53036a538bf40a39e81f3d7fb);
`endif

    // backpressure: ten stalled cycles in DONE
    d = rnd128();
    send(0, d);
    collect(0, 10, res);
    chk("bp_res", 0, res, model(d));
    tick();
    chk("bp_ready_after", 0, 128'(s_ir[0]), 128'h1);

    // reset on the second RUN cycle of the LANES=1 instance
    send(1, rnd128());
    tick();
    rst_a[1] = 1'b0;
    tick();
    rst_a[1] = 1'b1;
    tick();
    chk("rst_in_ready", 1, 128'(s_ir[1]), 128'h1);
    chk("rst_out_valid", 1, 128'(s_ov[1]), 128'h0);
    chk("rst_out_data", 1, s_od[1], 128'h0);
    send(1, {16{8'h7c}});
    collect(1, 0, res);
    chk("all7c", 1, res, {16{8'h01}});

    // random sweep over every lane count
    for (int k = 0; k < NI; k++) begin
      repeat (4) begin
        d = rnd128();
        repeat ($urandom_range(0, 2)) tick();
        send(k, d);
        collect(k, $urandom_range(0, 3), res);
        chk("rand_res", k, res, model(d));
      end
    end

    // back-to-back offers: one accept per N+2 cycles
    for (int k = 0; k < NI; k++) begin
      n = 16 / lanes_of(k);
      cnt = 0;
      iv_a[k] = 1'b1;
      or_a[k] = 1'b1;
      repeat (5 * (n + 2)) begin
        id_a[k] = rnd128();
        tick();
        if (s_ir[k]) cnt++;
      end
      iv_a[k] = 1'b0;
      chk("b2b_accepts", k, 128'(cnt), 128'd5);
      repeat (n + 3) tick();
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
